// File: rtl/fetch_prefetch_if.sv
// Memory-controller read channel of the prefetching fetch stage.
// The fetch stage is the master; the memory controller is the slave.
interface fetch_prefetch_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_mc_en;
   logic [ADDR_W-1:0] if_mc_addr;
   logic [DATA_W-1:0] mc_if_data;
   logic              mc_if_ready;

   modport master (
      output if_mc_en,
      output if_mc_addr,
      input  mc_if_data,
      input  mc_if_ready
   );

   modport slave (
      input  if_mc_en,
      input  if_mc_addr,
      output mc_if_data,
      output mc_if_ready
   );
endinterface

// File: rtl/fetch_prefetch.sv
// Prefetching instruction fetch: one outstanding read at a time, a DEPTH-entry
// FIFO of {instruction, next PC}, and redirect with squash of an in-flight read.
module fetch_prefetch #(
   parameter int                ADDR_W     = 32,
   parameter int                DATA_W     = 32,
   parameter int                DEPTH      = 4,
   parameter int                PC_INC     = 4,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0,
   parameter logic [ADDR_W-1:0] EXC_VECTOR = 'h80
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ex_if_stall,
   input  logic              id_if_selpcsource,
   input  logic [1:0]        id_if_selpctype,
   input  logic [ADDR_W-1:0] id_if_pcimd2ext,
   input  logic [ADDR_W-1:0] id_if_rega,
   input  logic [ADDR_W-1:0] id_if_pcindex,
   output logic              if_id_valid,
   output logic [DATA_W-1:0] if_id_instruc,
   output logic [ADDR_W-1:0] if_id_nextpc,
   fetch_prefetch_if.master  mem
);

   localparam int                PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0]    DEPTH_C = (PTR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);

   typedef enum logic {
      ST_RUN,
      ST_SQUASH
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_next;
   logic              r_req;
   logic              w_req_next;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] w_addr_next;

   logic [DATA_W-1:0] r_fifo_data [DEPTH];
   logic [ADDR_W-1:0] r_fifo_npc  [DEPTH];
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [PTR_W:0]    r_count;

   logic              w_valid;
   logic              w_push;
   logic              w_pop;
   logic              w_flush;
   logic              w_done;
   logic [ADDR_W-1:0] w_seq_pc;
   logic [ADDR_W-1:0] w_target;

   assign w_done   = r_req & mem.mc_if_ready;
   assign w_seq_pc = r_addr + PC_STEP;
   assign w_valid  = (r_count != '0);
   assign w_pop    = w_valid & ~ex_if_stall;

   always_comb begin
      w_target = EXC_VECTOR;
      case (id_if_selpctype)
         2'b00:   w_target = id_if_pcimd2ext;
         2'b01:   w_target = id_if_rega;
         2'b10:   w_target = id_if_pcindex;
         default: w_target = EXC_VECTOR;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_req_next   = r_req;
      w_addr_next  = r_addr;
      w_push       = 1'b0;
      w_flush      = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (id_if_selpcsource) begin
               w_flush   = 1'b1;
               w_pc_next = w_target;
               if (r_req && !mem.mc_if_ready) begin
                  // Address must stay stable until the controller answers.
                  w_state_next = ST_SQUASH;
               end else begin
                  w_req_next  = 1'b1;
                  w_addr_next = w_target;
               end
            end else if (w_done) begin
               w_push     = 1'b1;
               w_pc_next  = w_seq_pc;
               w_req_next = 1'b0;
            end else if (!r_req && (r_count < DEPTH_C)) begin
               w_req_next  = 1'b1;
               w_addr_next = r_pc;
            end
         end
         ST_SQUASH: begin
            if (id_if_selpcsource) begin
               w_flush   = 1'b1;
               w_pc_next = w_target;
            end
            if (mem.mc_if_ready) begin
               w_state_next = ST_RUN;
               w_req_next   = 1'b1;
               w_addr_next  = id_if_selpcsource ? w_target : r_pc;
            end
         end
         default: begin
            w_state_next = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_RUN;
         r_pc    <= RESET_PC;
         r_req   <= 1'b0;
         r_addr  <= '0;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
         r_req   <= w_req_next;
         r_addr  <= w_addr_next;
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_fifo_data[r_wptr] <= mem.mc_if_data;
         r_fifo_npc[r_wptr]  <= w_seq_pc;
      end
   end

   always_ff @(posedge clock) begin
      if (reset || w_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign if_id_valid   = w_valid;
   assign if_id_instruc = w_valid ? r_fifo_data[r_rptr] : '0;
   assign if_id_nextpc  = w_valid ? r_fifo_npc[r_rptr] : '0;
   assign mem.if_mc_en   = r_req;
   assign mem.if_mc_addr = r_addr;

endmodule

// File: doc/fetch_prefetch.md
Name: fetch_prefetch

Overview:
- Parametrised successor of the single-instruction fetch stage. Runs ahead of decode.
- Issues sequential instruction reads to the memory controller through a variable-latency ready handshake.
- Buffers up to DEPTH fetched instructions with their next-PC values in a FIFO.
- Flushes and squashes in-flight reads on a decode redirect, which selects among four PC sources.

Parameters:
ADDR_W, 32, width of PC and memory address
DATA_W, 32, instruction width
DEPTH, 4, prefetch FIFO entries (power of two, >=2)
PC_INC, 4, sequential PC increment
RESET_PC, 0, PC fetched after reset
EXC_VECTOR, 32'h80, redirect target for selpctype 2'b11

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
ex_if_stall  in  1  hold head instruction; no pop
id_if_selpcsource  in  1  redirect request this cycle
id_if_selpctype  in  2  00 pcimd2ext, 01 rega, 10 pcindex, 11 EXC_VECTOR
id_if_pcimd2ext  in  ADDR_W  branch target
id_if_rega  in  ADDR_W  jump-register target
id_if_pcindex  in  ADDR_W  jump-index target
if_id_valid  out  1  head entry valid
if_id_instruc  out  DATA_W  head instruction
if_id_nextpc  out  ADDR_W  head PC + PC_INC
if_mc_en  out  1  read request
if_mc_addr  out  ADDR_W  read address
mc_if_data  in  DATA_W  read data, valid when mc_if_ready=1
mc_if_ready  in  1  completes the current request this cycle

Behaviour:
- Reset, which has priority over everything:
  - fetch PC <= RESET_PC; FIFO empty; squash flag cleared; state RUN.
  - if_id_valid=0, if_id_instruc=0, if_id_nextpc=0, if_mc_en=0, if_mc_addr=0.
  - A reset in the middle of an outstanding read abandons that read. Any ready arriving afterwards is ignored while if_mc_en=0.
  - The first request is driven in the cycle after reset deasserts.
- Memory handshake:
  - Once if_mc_en=1, if_mc_addr stays constant until a cycle with mc_if_ready=1. That cycle completes the request.
  - At most one request is outstanding.
  - A new request may be driven in the cycle after completion. Throughput is 1 instruction per 2 cycles minimum; zero-wait back-to-back is not required.
- Issue condition, state RUN: if_mc_en=1 when (FIFO count + outstanding) < DEPTH and no redirect this cycle.
- Completion in RUN:
  - Push {mc_if_data, addr+PC_INC} into the FIFO.
  - PC <= addr+PC_INC, modulo 2^ADDR_W; wrap is allowed.
- Output:
  - if_id_* show the FIFO head combinationally from the registered FIFO.
  - Pop when if_id_valid && !ex_if_stall.
  - Simultaneous push and pop leaves the count unchanged.
  - A pop on an empty FIFO is impossible.
  - A full FIFO blocks issue only, never a pop.
- Redirect when id_if_selpcsource=1, honoured regardless of ex_if_stall:
  - At that edge, FIFO cleared and PC <= selected target.
  - If no request is outstanding, or the outstanding one completes in the same cycle: its data is discarded, state stays RUN, and the target is issued next cycle.
  - If a request is outstanding and not ready: go to SQUASH. if_mc_en and old address are held until ready, the data is discarded, then return to RUN and issue the target next cycle.
  - A redirect while in SQUASH updates PC to the newest target; only one discard occurs.
  - if_id_valid=0 in the cycle after any redirect.
- States: RUN and SQUASH only. SQUASH exits on mc_if_ready, or on reset.
- Best-case redirect to valid target instruction: target driven at N+1, ready at N+1, if_id_valid at N+2.

Test Plan:
- Reset then mc_if_ready always 1, no stall -> addresses 0,4,8,12... on alternate cycles; if_id_nextpc = 4,8,12 with matching data in order; if_mc_en=0 during reset.
- ex_if_stall=1 for 20 cycles with ready=1 -> exactly DEPTH=4 reads issued, then if_mc_en=0; head stays at nextpc=4. Release -> entries drain in order and issue resumes.
- Redirect cycle-by-cycle with selpctype 00/01/10/11, targets 0x100/0x200/0x300 -> next if_mc_addr equals target, 0x80 for 11; if_id_valid=0 in the cycle after redirect.
- Redirect while read at 0x8 is pending, ready delayed 3 cycles -> if_mc_addr holds 0x8 until ready; that data never appears on if_id_instruc; next request is to target.
- Redirect while the FIFO is full and stalled -> FIFO emptied, issue to target next cycle.
- Reset asserted during a pending read, and PC near 2^ADDR_W-4 -> no output after reset until the RESET_PC fetch; sequential fetch wraps to address 0.
